// File: rtl/plic_init_seq.sv
// plic_init_seq: programs PLIC priorities, enables and thresholds after reset
// or on start_i, stalling the upstream reg bridge. Once the sequence is done it
// becomes a zero-latency pass-through between the bridge and the PLIC.
module plic_init_seq #(
  parameter int                    SOURCE_NUM   = 32,
  parameter int                    TARGET_NUM   = 1,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [31:0]           PRIO_VALUE   = 32'd1,
  parameter logic [SOURCE_NUM-1:0] IE_VALUE     = {SOURCE_NUM{1'b1}} ^ SOURCE_NUM'(1),
  parameter logic [31:0]           THRESH_VALUE = 32'd0,
  parameter logic [ADDR_WIDTH-1:0] PRIO_BASE    = ADDR_WIDTH'(32'h0000000),
  parameter logic [ADDR_WIDTH-1:0] IE_BASE      = ADDR_WIDTH'(32'h0002000),
  parameter logic [ADDR_WIDTH-1:0] THRESH_BASE  = ADDR_WIDTH'(32'h0200000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  up_valid_i,
  input  logic                  up_write_i,
  input  logic [ADDR_WIDTH-1:0] up_addr_i,
  input  logic [DATA_WIDTH-1:0] up_wdata_i,
  input  logic [3:0]            up_wstrb_i,
  output logic [DATA_WIDTH-1:0] up_rdata_o,
  output logic                  up_error_o,
  output logic                  up_ready_o,
  output logic                  plic_valid_o,
  output logic                  plic_write_o,
  output logic [ADDR_WIDTH-1:0] plic_addr_o,
  output logic [DATA_WIDTH-1:0] plic_wdata_o,
  output logic [3:0]            plic_wstrb_o,
  input  logic [DATA_WIDTH-1:0] plic_rdata_i,
  input  logic                  plic_error_i,
  input  logic                  plic_ready_i
);

  localparam int W  = (SOURCE_NUM + 31) / 32;
  localparam int CW = 16;
  // enable mask zero-extended to whole 32-bit words
  localparam logic [W*32-1:0] IE_PAD = (W*32)'(IE_VALUE);

  typedef enum logic [2:0] {IDLE, PRIO, IE, THR, PASS} state_t;
  // a single-source PLIC has no programmable priorities
  localparam state_t FIRST = (SOURCE_NUM > 1) ? PRIO : IE;

  state_t          state;
  logic [CW-1:0]   s_q, t_q, w_q;
  logic            seq_valid, pend_q, busy_q, done_q, err_q;
  logic [ADDR_WIDTH-1:0] seq_addr;
  logic [31:0]     seq_wdata, ie_word;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;

  // select the current enable word with constant slices only
  always_comb begin
    ie_word = '0;
    for (int k = 0; k < W; k++)
      if (CW'(k) == w_q) ie_word = IE_PAD[32*k +: 32];
  end

  // sequencer FSM: each request is loaded in the cycle after the previous ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      s_q       <= '0;
      t_q       <= '0;
      w_q       <= '0;
      seq_valid <= 1'b0;
      seq_addr  <= '0;
      seq_wdata <= '0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state != PASS && seq_valid && plic_ready_i && plic_error_i)
        err_q <= 1'b1;
      case (state)
        IDLE: begin
          state  <= FIRST;
          s_q    <= CW'(1);
          t_q    <= '0;
          w_q    <= '0;
          busy_q <= 1'b1;
        end
        PRIO: begin
          if (!seq_valid) begin
            seq_valid <= 1'b1;
            seq_addr  <= PRIO_BASE + (ADDR_WIDTH'(s_q) << 2);
            seq_wdata <= PRIO_VALUE;
          end else if (plic_ready_i) begin
            seq_valid <= 1'b0;
            if (s_q == CW'(SOURCE_NUM - 1)) begin
              state <= IE;
              t_q   <= '0;
              w_q   <= '0;
            end else begin
              s_q <= s_q + CW'(1);
            end
          end
        end
        IE: begin
          if (!seq_valid) begin
            seq_valid <= 1'b1;
            seq_addr  <= IE_BASE + (ADDR_WIDTH'(t_q) << 7) + (ADDR_WIDTH'(w_q) << 2);
            seq_wdata <= ie_word;
          end else if (plic_ready_i) begin
            seq_valid <= 1'b0;
            if (w_q == CW'(W - 1)) begin
              w_q <= '0;
              if (t_q == CW'(TARGET_NUM - 1)) begin
                state <= THR;
                t_q   <= '0;
              end else begin
                t_q <= t_q + CW'(1);
              end
            end else begin
              w_q <= w_q + CW'(1);
            end
          end
        end
        THR: begin
          if (!seq_valid) begin
            if (t_q == CW'(TARGET_NUM)) begin
              state  <= PASS;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              seq_valid <= 1'b1;
              seq_addr  <= THRESH_BASE + (ADDR_WIDTH'(t_q) << 12);
              seq_wdata <= THRESH_VALUE;
            end
          end else if (plic_ready_i) begin
            seq_valid <= 1'b0;
            t_q       <= t_q + CW'(1);
          end
        end
        PASS: begin
          // restart only once no upstream transfer is left in flight
          if (start_i || pend_q) begin
            if (!up_valid_i || plic_ready_i) begin
              state  <= FIRST;
              s_q    <= CW'(1);
              t_q    <= '0;
              w_q    <= '0;
              busy_q <= 1'b1;
              err_q  <= 1'b0;
              pend_q <= 1'b0;
            end else begin
              pend_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // bus mux: sequencer owns the PLIC port until PASS, then straight wires
  always_comb begin
    plic_valid_o = seq_valid;
    plic_write_o = 1'b1;
    plic_addr_o  = seq_addr;
    plic_wdata_o = seq_wdata;
    plic_wstrb_o = 4'hF;
    up_rdata_o   = '0;
    up_error_o   = 1'b0;
    up_ready_o   = 1'b0;
    if (state == PASS) begin
      plic_valid_o = up_valid_i;
      plic_write_o = up_write_i;
      plic_addr_o  = up_addr_i;
      plic_wdata_o = up_wdata_i;
      plic_wstrb_o = up_wstrb_i;
      up_rdata_o   = plic_rdata_i;
      up_error_o   = plic_error_i;
      up_ready_o   = plic_ready_i;
    end
  end

endmodule

// File: tb/tb_plic_init_seq.sv
// Directed bench for plic_init_seq: default 32x1 instance exercised through
// all scenarios, plus a 40x2 instance checked for its write list.
module tb_plic_init_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst2 = 1'b1;
  logic        start_i = 1'b0;
  logic        up_valid = 1'b0, up_write = 1'b0;
  logic [31:0] up_addr = '0, up_wdata = '0;
  logic [3:0]  up_wstrb = '0;
  logic [31:0] plic_rdata = '0;
  logic        dly_mode = 1'b0, rdy_lvl = 1'b1, err_on_ie = 1'b0;

  logic        busy_o, done_o, err_o, up_error_o, up_ready_o;
  logic [31:0] up_rdata_o;
  logic        plic_valid_o, plic_write_o;
  logic [31:0] plic_addr_o, plic_wdata_o;
  logic [3:0]  plic_wstrb_o;
  logic        plic_ready_i, plic_error_i;

  logic        busy2, done2, err2, up_err2, up_rdy2, pv2, pw2;
  logic [31:0] up_rd2, pa2, pd2;
  logic [3:0]  ps2;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_ack = 0, wc = 0, stab_err = 0, stall_err = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_a, hold_d;
  logic [31:0] log_a[$], log_d[$], log2_a[$], log2_d[$];

  always #5 clk = ~clk;

  assign plic_ready_i = dly_mode ? (plic_valid_o && wc == 3) : rdy_lvl;
  assign plic_error_i = err_on_ie && plic_valid_o && plic_addr_o == 32'h2000;

  plic_init_seq dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .up_valid_i(up_valid), .up_write_i(up_write), .up_addr_i(up_addr),
    .up_wdata_i(up_wdata), .up_wstrb_i(up_wstrb),
    .up_rdata_o(up_rdata_o), .up_error_o(up_error_o), .up_ready_o(up_ready_o),
    .plic_valid_o(plic_valid_o), .plic_write_o(plic_write_o), .plic_addr_o(plic_addr_o),
    .plic_wdata_o(plic_wdata_o), .plic_wstrb_o(plic_wstrb_o),
    .plic_rdata_i(plic_rdata), .plic_error_i(plic_error_i), .plic_ready_i(plic_ready_i)
  );

  plic_init_seq #(.SOURCE_NUM(40), .TARGET_NUM(2), .IE_VALUE({{39{1'b1}}, 1'b0})) dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(1'b0),
    .busy_o(busy2), .done_o(done2), .err_o(err2),
    .up_valid_i(1'b0), .up_write_i(1'b0), .up_addr_i(32'h0),
    .up_wdata_i(32'h0), .up_wstrb_i(4'h0),
    .up_rdata_o(up_rd2), .up_error_o(up_err2), .up_ready_o(up_rdy2),
    .plic_valid_o(pv2), .plic_write_o(pw2), .plic_addr_o(pa2),
    .plic_wdata_o(pd2), .plic_wstrb_o(ps2),
    .plic_rdata_i(32'h0), .plic_error_i(1'b0), .plic_ready_i(1'b1)
  );

  // bus monitor: logs sequencer writes, checks request stability and stall
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (plic_valid_o && plic_ready_i) wc <= 0;
    else if (plic_valid_o)            wc <= wc + 1;
    else                              wc <= 0;
    if (busy_o && plic_valid_o && plic_ready_i) begin
      log_a.push_back(plic_addr_o);
      log_d.push_back(plic_wdata_o);
      last_ack <= cyc;
    end
    if (busy2 && pv2) begin
      log2_a.push_back(pa2);
      log2_d.push_back(pd2);
    end
    if (busy_o && up_ready_o) stall_err <= stall_err + 1;
    if (rst) hold_v <= 1'b0;
    else begin
      if (hold_v && !(plic_valid_o && plic_addr_o == hold_a && plic_wdata_o == hold_d))
        stab_err <= stab_err + 1;
      hold_v <= busy_o && plic_valid_o && !plic_ready_i;
      hold_a <= plic_addr_o;
      hold_d <= plic_wdata_o;
    end
  end

  // expected write list of the default 32-source, 1-target instance
  function automatic logic [31:0] exp_a1(int i);
    if (i < 31) return 32'(4 * (i + 1));
    if (i == 31) return 32'h2000;
    return 32'h200000;
  endfunction
  function automatic logic [31:0] exp_d1(int i);
    if (i < 31) return 32'd1;
    if (i == 31) return 32'hFFFF_FFFE;
    return 32'd0;
  endfunction
  // expected write list of the 40-source, 2-target instance
  function automatic logic [31:0] exp_a2(int i);
    if (i < 39) return 32'(4 * (i + 1));
    if (i < 43) return 32'h2000 + 32'(((i - 39) / 2) * 32'h80) + 32'(((i - 39) % 2) * 4);
    return 32'h200000 + 32'((i - 43) * 32'h1000);
  endfunction
  function automatic logic [31:0] exp_d2(int i);
    if (i < 39) return 32'd1;
    if (i < 43) return ((i - 39) % 2) ? 32'hFF : 32'hFFFF_FFFE;
    return 32'd0;
  endfunction

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy_o !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (n >= 1000) begin
      $display("FAIL %s: timeout, busy_o=%b required 0", nm, busy_o);
      n_fail++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (busy_o !== 1'b0)       begin $display("FAIL rst_busy: got %b want 0", busy_o); n_fail++; end
    n_chk++; if (done_o !== 1'b0)       begin $display("FAIL rst_done: got %b want 0", done_o); n_fail++; end
    n_chk++; if (err_o !== 1'b0)        begin $display("FAIL rst_err: got %b want 0", err_o); n_fail++; end
    n_chk++; if (plic_valid_o !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", plic_valid_o); n_fail++; end
    n_chk++; if (up_ready_o !== 1'b0)   begin $display("FAIL rst_up_ready: got %b want 0", up_ready_o); n_fail++; end
  endtask

  task automatic test_seq_fast();
    log_a.delete(); log_d.delete();
    rdy_lvl = 1'b1;
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) begin $display("FAIL fast_busy: got %b want 1", busy_o); n_fail++; end
    wait_idle("fast_done");
    n_chk++; if (done_o !== 1'b1) begin $display("FAIL fast_done: got %b want 1", done_o); n_fail++; end
    n_chk++; if (cyc != last_ack + 2) begin $display("FAIL fast_done_lat: got %0d want %0d", cyc - last_ack, 2); n_fail++; end
    n_chk++; if (log_a.size() != 33) begin $display("FAIL fast_count: got %0d want 33", log_a.size()); n_fail++; end
    for (int i = 0; i < log_a.size() && i < 33; i++) begin
      n_chk++;
      if (log_a[i] !== exp_a1(i) || log_d[i] !== exp_d1(i)) begin
        $display("FAIL fast_wr%0d: got %h/%h want %h/%h", i, log_a[i], log_d[i], exp_a1(i), exp_d1(i));
        n_fail++;
      end
    end
    n_chk++; if (err_o !== 1'b0) begin $display("FAIL fast_err: got %b want 0", err_o); n_fail++; end
  endtask

  task automatic test_delay_stall();
    log_a.delete(); log_d.delete();
    stab_err = 0; stall_err = 0;
    dly_mode = 1'b1;
    pulse_start();
    up_valid = 1'b1; up_write = 1'b0; up_addr = 32'h200004;
    n_chk++; if (busy_o !== 1'b1) begin $display("FAIL dly_busy: got %b want 1", busy_o); n_fail++; end
    n_chk++; if (done_o !== 1'b1) begin $display("FAIL dly_done_held: got %b want 1", done_o); n_fail++; end
    wait_idle("dly_done");
    dly_mode = 1'b0; rdy_lvl = 1'b0; plic_rdata = 32'h5;
    #1;
    n_chk++; if (plic_valid_o !== 1'b1 || plic_addr_o !== 32'h200004 || plic_write_o !== 1'b0) begin
      $display("FAIL pass_req: got v=%b a=%h w=%b want 1/00200004/0", plic_valid_o, plic_addr_o, plic_write_o); n_fail++; end
    n_chk++; if (up_ready_o !== 1'b0) begin $display("FAIL pass_noready: got %b want 0", up_ready_o); n_fail++; end
    rdy_lvl = 1'b1;
    #1;
    n_chk++; if (up_ready_o !== 1'b1 || up_rdata_o !== 32'h5) begin
      $display("FAIL pass_rdata: got r=%b d=%h want 1/00000005", up_ready_o, up_rdata_o); n_fail++; end
    @(negedge clk);
    up_valid = 1'b0;
    n_chk++; if (stab_err != 0)  begin $display("FAIL dly_stable: got %0d unstable want 0", stab_err); n_fail++; end
    n_chk++; if (stall_err != 0) begin $display("FAIL dly_stall: got %0d up_ready while busy want 0", stall_err); n_fail++; end
    n_chk++; if (log_a.size() != 33) begin $display("FAIL dly_count: got %0d want 33", log_a.size()); n_fail++; end
    for (int i = 0; i < log_a.size() && i < 33; i++) begin
      n_chk++;
      if (log_a[i] !== exp_a1(i) || log_d[i] !== exp_d1(i)) begin
        $display("FAIL dly_wr%0d: got %h/%h want %h/%h", i, log_a[i], log_d[i], exp_a1(i), exp_d1(i));
        n_fail++;
      end
    end
  endtask

  task automatic test_error();
    int n = 0;
    log_a.delete(); log_d.delete();
    rdy_lvl = 1'b1; err_on_ie = 1'b1;
    pulse_start();
    while (!(plic_valid_o && plic_addr_o == 32'h2000) && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_chk++; if (n >= 500) begin $display("FAIL err_ie_seen: timeout, addr=%h want 00002000", plic_addr_o); n_fail++; end
    n_chk++; if (err_o !== 1'b0) begin $display("FAIL err_before: got %b want 0", err_o); n_fail++; end
    @(negedge clk);
    n_chk++; if (err_o !== 1'b1) begin $display("FAIL err_after: got %b want 1", err_o); n_fail++; end
    wait_idle("err_done");
    err_on_ie = 1'b0;
    n_chk++; if (log_a.size() != 33 || log_a[log_a.size()-1] !== 32'h200000) begin
      $display("FAIL err_thr: got n=%0d last=%h want 33/00200000", log_a.size(), log_a[log_a.size()-1]); n_fail++; end
    n_chk++; if (done_o !== 1'b1 || err_o !== 1'b1) begin
      $display("FAIL err_final: got done=%b err=%b want 1/1", done_o, err_o); n_fail++; end
  endtask

  task automatic test_start_pending();
    log_a.delete(); log_d.delete();
    @(negedge clk);
    up_valid = 1'b1; up_write = 1'b1; up_addr = 32'h10; up_wdata = 32'hA5A5; up_wstrb = 4'h3;
    rdy_lvl = 1'b0; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    n_chk++; if (busy_o !== 1'b0 || err_o !== 1'b1) begin
      $display("FAIL pend_hold: got busy=%b err=%b want 0/1", busy_o, err_o); n_fail++; end
    n_chk++; if (plic_valid_o !== 1'b1 || plic_addr_o !== 32'h10 || plic_write_o !== 1'b1 ||
                 plic_wdata_o !== 32'hA5A5 || plic_wstrb_o !== 4'h3) begin
      $display("FAIL pend_fwd: got v=%b a=%h w=%b d=%h s=%h want 1/00000010/1/0000a5a5/3",
               plic_valid_o, plic_addr_o, plic_write_o, plic_wdata_o, plic_wstrb_o); n_fail++; end
    rdy_lvl = 1'b1;
    #1;
    n_chk++; if (up_ready_o !== 1'b1) begin $display("FAIL pend_ack: got %b want 1", up_ready_o); n_fail++; end
    @(negedge clk);
    up_valid = 1'b0;
    n_chk++; if (busy_o !== 1'b1 || err_o !== 1'b0 || done_o !== 1'b1) begin
      $display("FAIL pend_restart: got busy=%b err=%b done=%b want 1/0/1", busy_o, err_o, done_o); n_fail++; end
    wait_idle("pend_done");
    n_chk++; if (log_a.size() != 33 || log_a[0] !== 32'h4) begin
      $display("FAIL pend_list: got n=%0d first=%h want 33/00000004", log_a.size(), log_a[0]); n_fail++; end
  endtask

  task automatic test_reset_abort();
    pulse_start();
    repeat (8) @(negedge clk);
    n_chk++; if (busy_o !== 1'b1) begin $display("FAIL abort_busy: got %b want 1", busy_o); n_fail++; end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (plic_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      $display("FAIL abort_state: got v=%b busy=%b done=%b want 0/0/0", plic_valid_o, busy_o, done_o); n_fail++; end
    log_a.delete(); log_d.delete();
    rst = 1'b0;
    @(negedge clk);
    wait_idle("abort_done");
    n_chk++; if (log_a.size() != 33) begin $display("FAIL abort_count: got %0d want 33", log_a.size()); n_fail++; end
    for (int i = 0; i < log_a.size() && i < 33; i += 8) begin
      n_chk++;
      if (log_a[i] !== exp_a1(i)) begin
        $display("FAIL abort_wr%0d: got %h want %h", i, log_a[i], exp_a1(i)); n_fail++; end
    end
  endtask

  task automatic test_multi();
    n_chk++; if (done2 !== 1'b1) begin $display("FAIL multi_done: got %b want 1", done2); n_fail++; end
    n_chk++; if (log2_a.size() != 45) begin $display("FAIL multi_count: got %0d want 45", log2_a.size()); n_fail++; end
    for (int i = 0; i < log2_a.size() && i < 45; i++) begin
      n_chk++;
      if (log2_a[i] !== exp_a2(i) || log2_d[i] !== exp_d2(i)) begin
        $display("FAIL multi_wr%0d: got %h/%h want %h/%h", i, log2_a[i], log2_d[i], exp_a2(i), exp_d2(i));
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_fast();
    test_delay_stall();
    test_error();
    test_start_pending();
    test_multi();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
